// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared fetch-stage FSM encodings and opcode field position.
package instr_fetch_pkg;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_WAIT = 1'b1
    } fetch_state_e;

    // The opcode occupies the top bits of the instruction word.
    function automatic int opcode_lsb(input int data_width, input int opcode_width);
        return data_width - opcode_width;
    endfunction

endpackage

// File: rtl/program_counter.sv
// program_counter: PC register with jump load, wrapping increment and sync reset.
module program_counter #(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  inc,
    input  logic [ADDR_WIDTH-1:0] load_val,
    output logic [ADDR_WIDTH-1:0] pc
);

    logic [ADDR_WIDTH-1:0] pc_d, pc_q;

    always_comb pc_d = load ? load_val : inc ? pc_q + 1'b1 : pc_q;

    always_ff @(posedge clock) pc_q <= reset ? RESET_PC : pc_d;

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC ownership, req/ack program-memory read and instruction register.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    OPCODE_WIDTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               fetch,
    input  logic                               pc_load,
    input  logic [ADDR_WIDTH-1:0]              pc_in,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    output logic                               mem_req,
    input  logic                               mem_ack,
    input  logic [DATA_WIDTH-1:0]              mem_data,
    output logic [OPCODE_WIDTH-1:0]            opcode,
    output logic [DATA_WIDTH-OPCODE_WIDTH-1:0] operand,
    output logic [ADDR_WIDTH-1:0]              pc,
    output logic                               busy,
    output logic                               ir_valid
);

    localparam int OP_LSB = opcode_lsb(DATA_WIDTH, OPCODE_WIDTH);

    fetch_state_e          state_d, state_q;
    logic                  mem_req_d, mem_req_q;
    logic [ADDR_WIDTH-1:0] mem_addr_d, mem_addr_q;
    logic [DATA_WIDTH-1:0] ir_d, ir_q;
    logic                  ir_valid_d, ir_valid_q;
    logic                  pc_ld, pc_inc;

    // A jump issued with a fetch also lands in the PC, so pc == mem_addr throughout WAIT
    // and the ack increment yields mem_addr + 1.
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        pc_ld      = 1'b0;
        pc_inc     = 1'b0;
        if (state_q == FETCH_IDLE) begin
            pc_ld = pc_load;
            if (fetch) begin
                state_d    = FETCH_WAIT;
                mem_req_d  = 1'b1;
                mem_addr_d = pc_load ? pc_in : pc;
            end
        end else if (mem_ack) begin
            state_d    = FETCH_IDLE;
            mem_req_d  = 1'b0;
            ir_d       = mem_data;
            ir_valid_d = 1'b1;
            pc_inc     = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= FETCH_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    program_counter #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .RESET_PC  (RESET_PC)
    ) u_pc (
        .clock   (clock),
        .reset   (reset),
        .load    (pc_ld),
        .inc     (pc_inc),
        .load_val(pc_in),
        .pc      (pc)
    );

    assign mem_addr = mem_addr_q;
    assign mem_req  = mem_req_q;
    assign opcode   = ir_q[OP_LSB +: OPCODE_WIDTH];
    assign operand  = ir_q[OP_LSB-1:0];
    assign busy     = (state_q == FETCH_WAIT);
    assign ir_valid = ir_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table-driven fetches, hand-written corner sequences and random
// stimulus checked against a transaction-level reference model.
module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        reset, fetch, pc_load, mem_ack;
    logic [7:0]  pc_in, mem_addr, pc;
    logic        mem_req, busy, ir_valid;
    logic [15:0] mem_data;
    logic [1:0]  opcode;
    logic [13:0] operand;

    int tests = 0;
    int fails = 0;

    // Reference model: what the spec says is architecturally visible.
    logic [7:0]  m_pc, m_addr;
    logic [15:0] m_ir;
    logic        m_valid, m_busy;

    typedef struct {
        logic        pl;
        logic [7:0]  target;
        int          waits;
        logic [15:0] data;
        logic [1:0]  exp_op;
        logic [13:0] exp_operand;
        logic [7:0]  exp_pc;
        logic [7:0]  exp_addr;
    } vec_t;

    vec_t vecs[5];

    instr_fetch dut (
        .clock   (clock),
        .reset   (reset),
        .fetch   (fetch),
        .pc_load (pc_load),
        .pc_in   (pc_in),
        .mem_addr(mem_addr),
        .mem_req (mem_req),
        .mem_ack (mem_ack),
        .mem_data(mem_data),
        .opcode  (opcode),
        .operand (operand),
        .pc      (pc),
        .busy    (busy),
        .ir_valid(ir_valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic quiet();
        fetch    = 1'b0;
        pc_load  = 1'b0;
        mem_ack  = 1'b0;
        reset    = 1'b0;
        pc_in    = 8'h00;
        mem_data = 16'h0000;
    endtask

    // One clock: advance the model with the inputs the DUT sees at this edge, then compare.
    task automatic cyc();
        @(posedge clock);
        if (reset) begin
            m_pc = 8'h00; m_ir = 16'h0000; m_valid = 1'b0; m_busy = 1'b0; m_addr = 8'h00;
        end else if (!m_busy) begin
            if (fetch) begin
                m_addr = pc_load ? pc_in : m_pc;
                m_busy = 1'b1;
            end else if (pc_load) begin
                m_pc = pc_in;
            end
        end else if (mem_ack) begin
            m_ir    = mem_data;
            m_valid = 1'b1;
            m_pc    = 8'((int'(m_addr) + 1) % 256);
            m_busy  = 1'b0;
        end
        #1;
        chk("busy", busy, m_busy);
        chk("mem_req", mem_req, m_busy);
        if (m_busy) chk("mem_addr", mem_addr, m_addr);
        chk("opcode", opcode, m_ir[15:14]);
        chk("operand", operand, m_ir[13:0]);
        chk("ir_valid", ir_valid, m_valid);
        if (!m_busy) chk("pc", pc, m_pc);
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0]  old_pc;
        logic [1:0]  old_op;
        int          req_cycles;
        m_pc = 8'h00; m_ir = 16'h0000; m_valid = 1'b0; m_busy = 1'b0; m_addr = 8'h00;
        vecs[0] = '{1'b0, 8'h00, 0, 16'h8000, 2'b10, 14'h0000, 8'h01, 8'h00};
        vecs[1] = '{1'b0, 8'h00, 3, 16'h4ABC, 2'b01, 14'h0ABC, 8'h02, 8'h01};
        vecs[2] = '{1'b1, 8'h40, 1, 16'hC123, 2'b11, 14'h0123, 8'h41, 8'h40};
        vecs[3] = '{1'b0, 8'h00, 2, 16'h3FFF, 2'b00, 14'h3FFF, 8'h42, 8'h41};
        vecs[4] = '{1'b1, 8'hFF, 0, 16'h0005, 2'b00, 14'h0005, 8'h00, 8'hFF};

        do_reset();
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_pc", pc, 8'h00);
        chk("rst_ir_valid", ir_valid, 1'b0);
        chk("rst_opcode", opcode, 2'b00);

        foreach (vecs[i]) begin
            old_op     = opcode;
            req_cycles = 0;
            fetch   = 1'b1;
            pc_load = vecs[i].pl;
            pc_in   = vecs[i].target;
            cyc();
            quiet();
            chk("vec_addr", mem_addr, vecs[i].exp_addr);
            for (int w = 0; w < vecs[i].waits; w++) begin
                req_cycles += int'(mem_req);
                cyc();
                chk("vec_addr_hold", mem_addr, vecs[i].exp_addr);
                chk("vec_op_hold", opcode, old_op);
            end
            req_cycles += int'(mem_req);
            mem_ack  = 1'b1;
            mem_data = vecs[i].data;
            cyc();
            quiet();
            chk("vec_req_cycles", req_cycles, vecs[i].waits + 1);
            chk("vec_opcode", opcode, vecs[i].exp_op);
            chk("vec_operand", operand, vecs[i].exp_operand);
            chk("vec_pc", pc, vecs[i].exp_pc);
            chk("vec_valid", ir_valid, 1'b1);
            chk("vec_req_low", mem_req, 1'b0);
            cyc();
        end

        // fetch and pc_load pulsed mid-WAIT must be ignored
        old_pc = pc;
        fetch = 1'b1;
        cyc();
        quiet();
        cyc();
        fetch = 1'b1; pc_load = 1'b1; pc_in = 8'h10;
        cyc();
        quiet();
        chk("ign_addr", mem_addr, old_pc);
        mem_ack = 1'b1; mem_data = 16'h7777;
        cyc();
        quiet();
        chk("ign_pc", pc, old_pc + 8'h01);
        cyc();
        chk("ign_no_second_req", mem_req, 1'b0);

        // pc_load alone in IDLE jumps without touching IR
        pc_load = 1'b1; pc_in = 8'h80;
        cyc();
        quiet();
        chk("jump_pc", pc, 8'h80);
        chk("jump_op_kept", opcode, 2'b01);

        // reset mid-WAIT abandons the fetch; a late ack is ignored
        fetch = 1'b1;
        cyc();
        quiet();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rmid_req", mem_req, 1'b0);
        chk("rmid_pc", pc, 8'h00);
        chk("rmid_valid", ir_valid, 1'b0);
        mem_ack = 1'b1; mem_data = 16'hFFFF;
        cyc();
        quiet();
        chk("late_ack_op", opcode, 2'b00);
        chk("late_ack_valid", ir_valid, 1'b0);

        for (int n = 0; n < 600; n++) begin
            reset    = ($urandom_range(0, 59) == 0);
            fetch    = ($urandom_range(0, 2) == 0);
            pc_load  = ($urandom_range(0, 3) == 0);
            pc_in    = 8'($urandom);
            mem_ack  = ($urandom_range(0, 1) == 0);
            mem_data = 16'($urandom);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of the microsequencer. It owns the program counter and runs a request/acknowledge read against program memory. It latches the returned word into an instruction register and presents the opcode field to the microsequencer's `opcode` input. A fetch is triggered by one control bit of the microsequencer's control word, and the opcode stays stable until the next fetch completes.

## Interface
- `ADDR_WIDTH`, 8: program counter and memory address width.
- `DATA_WIDTH`, 16: instruction word width.
- `OPCODE_WIDTH`, 2: opcode field width, taken from the word MSBs; must be less than `DATA_WIDTH`.
- `RESET_PC`, 0: program counter value after reset.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fetch`  in  1  single-cycle request from the microsequencer control word to fetch the next instruction.
- `pc_load`  in  1  load `pc_in` into the PC (jump).
- `pc_in`  in  `ADDR_WIDTH`  jump target.
- `mem_addr`  out  `ADDR_WIDTH`  read address; registered; valid while `mem_req`=1.
- `mem_req`  out  1  read request, registered.
- `mem_ack`  in  1  memory has valid `mem_data` this cycle.
- `mem_data`  in  `DATA_WIDTH`  instruction word.
- `opcode`  out  `OPCODE_WIDTH`  IR[DATA_WIDTH-1 -: OPCODE_WIDTH]; feeds the microsequencer.
- `operand`  out  `DATA_WIDTH-OPCODE_WIDTH`  remaining IR bits.
- `pc`  out  `ADDR_WIDTH`  current program counter.
- `busy`  out  1  fetch in progress.
- `ir_valid`  out  1  IR holds a fetched word.

## Operation
- FSM states: IDLE and WAIT.
- IDLE with `fetch`=1 → WAIT. At that edge: `mem_addr`←effective PC, `mem_req`←1.
- WAIT with `mem_ack`=0 → WAIT. `mem_req` and `mem_addr` are held unchanged.
- WAIT with `mem_ack`=1 → IDLE. At that edge:
  - IR←`mem_data`
  - `ir_valid`←1
  - `pc`←`mem_addr`+1, modulo 2^`ADDR_WIDTH` (wraps all-ones → 0)
  - `mem_req`←0
- Effective PC in IDLE is `pc_in` if `pc_load`=1, else `pc`.
- `pc_load`=1 in IDLE without `fetch`: `pc`←`pc_in`. `ir_valid` and IR are unchanged.
- `pc_load` and `fetch` together in IDLE: fetch issues from `pc_in`. The final PC after ack is `pc_in`+1.
- `fetch` or `pc_load` during WAIT: ignored. No queuing; the PC is unaffected.
- `mem_ack` in IDLE: ignored. `mem_data` is sampled only in WAIT.
- `opcode`/`operand` hold the previous IR throughout WAIT and change only on the ack edge.
- `busy` = (state == WAIT).
- Reset values:
  - state IDLE
  - `pc`=`RESET_PC`
  - IR=0, so `opcode`=0 and `operand`=0
  - `ir_valid`=0, `mem_req`=0, `mem_addr`=`RESET_PC`
- Reset has priority over everything, including mid-WAIT: `mem_req` drops at that edge and the pending ack is abandoned.

## Timing
- Fetch sampled at edge N: `mem_req`=1 from N until the edge at which ack is sampled.
- Ack may arrive in the first cycle `mem_req` is high. Minimum fetch-to-new-opcode latency is therefore 2 edges; the general case is 2 + wait cycles.
- `busy` rises at edge N and falls at the ack edge.
- One fetch is outstanding at most. Back-to-back fetches need a `fetch` pulse in the IDLE cycle after the ack, giving a throughput of one instruction per 2 cycles at zero wait states.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared header, alongside the existing globals:
  - FSM state encodings `FETCH_IDLE`=0 and `FETCH_WAIT`=1
  - opcode field position macro
- One sub-module, `program_counter`: holds the PC, with load, increment and wrap, and synchronous reset to `RESET_PC`.
- FSM, IR and memory-interface registers stay in `instr_fetch`.

## Test plan
- Reset then single fetch: reset 2 cycles; `fetch` pulse; memory acks the same cycle with 16'h8000.
  - Response: `opcode`=2'b10, `operand`=0, `pc`=1, `ir_valid`=1, `mem_req` high exactly 1 cycle.
- Wait states: ack delayed 3 cycles, data 16'h4ABC.
  - During WAIT: `mem_addr` stable and `opcode` keeps its old value.
  - After ack: `opcode`=2'b01, `operand`=14'h0ABC.
- Jump with fetch: `pc_load`=1, `pc_in`=8'h40 and `fetch`=1 in the same cycle.
  - Response: `mem_addr`=8'h40; after ack `pc`=8'h41.
- Ignored inputs during WAIT: `fetch` and `pc_load` (`pc_in`=8'h10) pulsed mid-WAIT.
  - Response: no second request; after ack `pc`=old+1.
- Wrap and reset mid-fetch:
  - PC=8'hFF fetch → `pc`=8'h00 after ack.
  - Next fetch with reset asserted in WAIT → `mem_req`=0, `pc`=`RESET_PC`, `ir_valid`=0 next cycle; a late ack is ignored.
